if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Pipeline fetch stage plus IF/ID register, directly upstream of the decode-stage control decoder.
- Generates the PC and issues requests to instruction memory over a valid/ready interface, tolerating variable response latency.
- Buffers returned instructions in a small FIFO and presents {instr, pc, pc+4} plus the pre-sliced op/funct3/funct7[5] fields to decode.
- Handles branch/jump redirect, decode stall and decode flush.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, fetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, stable while valid && !ready
imem_rsp_valid  in  1  instruction returned (in order, one per accepted request)
imem_rsp_data  in  XLEN  returned instruction
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  XLEN  redirect target
stall_d  in  1  hold IF/ID contents
flush_d  in  1  invalidate IF/ID
instr_d  out  XLEN  instruction to decode
pc_d  out  XLEN  PC of instr_d
pc_plus4_d  out  XLEN  pc_d+4 (for jal link)
valid_d  out  1  instr_d is real
op_d  out  7  instr_d[6:0]
funct3_d  out  3  instr_d[14:12]
funct7_5_d  out  1  instr_d[30]

Behaviour:
- Reset (sync, active-high):
  - pc_f=RESET_PC; FSM=IDLE; FIFO empty.
  - valid_d=0, instr_d=32'h0000_0013 (NOP), pc_d=0, pc_plus4_d=4.
  - imem_req_valid=0 during reset.
  - Reset mid-transaction abandons any outstanding response; memory side is reset alongside.
- FSM states:
  - IDLE: go to REQ next cycle.
  - REQ: imem_req_valid = (occupancy<BUF_DEPTH) && !redirect_valid; imem_req_addr=pc_f. On valid&&ready: pc_req<=pc_f, pc_f<=pc_f+4, go to WAIT.
  - WAIT: imem_req_valid=0, so at most one request is outstanding. On imem_rsp_valid: push {pc_req, data}, go to REQ.
  - DROP: imem_req_valid=0. On imem_rsp_valid: discard the response, go to REQ.
- Redirect (highest priority, any state):
  - pc_f<=redirect_pc; FIFO cleared; IF/ID invalidated.
  - WAIT without rsp this cycle -> DROP.
  - WAIT with rsp this cycle -> response discarded, go to REQ.
  - DROP stays in DROP.
  - IDLE/REQ -> REQ. No request is accepted in the redirect cycle.
- FIFO:
  - Push only in WAIT on rsp without redirect; pop on IF/ID load. Simultaneous push+pop keeps occupancy.
  - Overflow is impossible: issue requires occupancy<BUF_DEPTH and occupancy cannot grow while outstanding.
  - Pointers wrap modulo BUF_DEPTH.
- IF/ID update, in priority order:
  1. redirect_valid or flush_d: valid_d<=0, instr_d<=NOP; pc_d/pc_plus4_d hold. Flush beats stall; the FIFO does not pop.
  2. stall_d: all IF/ID outputs hold; no pop. Fetch continues until the FIFO is full.
  3. FIFO nonempty: pop head into instr_d/pc_d; pc_plus4_d<=head.pc+4; valid_d<=1.
  4. FIFO empty: valid_d<=0, instr_d<=NOP.
- Latency: with 1-cycle memory, request acceptance at edge N gives valid_d=1 after edge N+2.
- PC arithmetic is modulo 2^XLEN: pc_f=FFFF_FFFC wraps to 0.
- op_d/funct3_d/funct7_5_d are pure slices of instr_d (NOP gives op 0010011).

Optional Feature:
IF_FETCH_BYPASS_EN
- Defined: in WAIT with rsp, FIFO empty, !stall_d, !flush_d, !redirect_valid, the response loads IF/ID directly (no push). Request-to-valid_d latency drops by one: acceptance at edge N -> valid_d after edge N+1.
- Undefined: every response passes through the FIFO, per the latency above.

Test Plan:
- Reset release, ready=1, 1-cycle rsp with data=0x00500093 -> first imem_req_addr=0x0; valid_d=1 with instr_d=0x00500093, pc_d=0, pc_plus4_d=4, op_d=0010011, funct3_d=000; following fetches at 4, 8, 12.
- stall_d held 6 cycles during streaming -> instr_d/pc_d frozen; fetching stops with exactly BUF_DEPTH=2 entries buffered; on release, pc_d advances 4-by-4 with no gaps or duplicates.
- redirect_valid to 0x100 while in WAIT, response arrives 3 cycles later -> that response is dropped; next imem_req_addr=0x100; valid_d=0 until 0x100's instruction arrives.
- redirect coinciding with imem_rsp_valid, plus flush_d+stall_d asserted together -> the response is discarded; flush wins: valid_d=0, instr_d=0x00000013.
- imem_req_ready held low 5 cycles -> imem_req_valid=1 and imem_req_addr constant throughout; pc_f advances only on acceptance.
- RESET_PC=32'hFFFF_FFFC -> second request addr=0x0 (wrap); mid-WAIT reset returns to RESET_PC, FIFO empty, valid_d=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Fetch stage and IF/ID register: PC generation, imem valid/ready requests, response FIFO, redirect/stall/flush.
// Optional IF_FETCH_BYPASS_EN: a response that finds the FIFO empty loads IF/ID directly, saving one cycle.
module if_fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic [6:0]      op_d,
  output logic [2:0]      funct3_d,
  output logic            funct7_5_d
);

  localparam int unsigned     PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned     CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam logic [XLEN-1:0] NOP    = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_f_q, pc_f_d;
  logic [XLEN-1:0]   pc_req_q, pc_req_d;
  logic [XLEN-1:0]   buf_instr_q [BUF_DEPTH];
  logic [XLEN-1:0]   buf_instr_d [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc_q    [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc_d    [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0]   ifid_pc4_q, ifid_pc4_d;

  logic req_valid_c;
  logic rsp_take_c;
  logic bypass_ok_c;
  logic bypass_c;
  logic push_c;
  logic pop_c;

`ifdef IF_FETCH_BYPASS_EN
  assign bypass_ok_c = (count_q == '0) && !stall_d && !flush_d;
`else
  assign bypass_ok_c = 1'b0;
`endif

  // Fetch FSM: one outstanding request; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    pc_req_d    = pc_req_q;
    req_valid_c = 1'b0;
    rsp_take_c  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req_valid_c = (count_q < CNT_W'(BUF_DEPTH)) && !redirect_valid;
        if (req_valid_c && imem_req_ready) begin
          pc_req_d = pc_f_q;
          pc_f_d   = pc_f_q + PC_INC;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d    = S_REQ;
          rsp_take_c = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: if (imem_rsp_valid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_f_d = redirect_pc;
      if (state_q == S_IDLE || state_q == S_REQ) state_d = S_REQ;
    end
  end

  assign bypass_c       = rsp_take_c && bypass_ok_c;
  assign push_c         = rsp_take_c && !bypass_ok_c;
  assign pop_c          = !redirect_valid && !flush_d && !stall_d && !bypass_c && (count_q != '0);
  assign imem_req_valid = req_valid_c && !reset;
  assign imem_req_addr  = pc_f_q;

  // Response FIFO; a redirect empties it.
  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) begin
      buf_instr_d[wr_ptr_q] = imem_rsp_data;
      buf_pc_d[wr_ptr_q]    = pc_req_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // IF/ID register: kill > stall > load (bypass or FIFO head) > bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (redirect_valid || flush_d) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP;
    end else if (stall_d) begin
      ifid_valid_d = ifid_valid_q;
    end else if (bypass_c) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = imem_rsp_data;
      ifid_pc_d    = pc_req_q;
      ifid_pc4_d   = pc_req_q + PC_INC;
    end else if (pop_c) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = buf_instr_q[rd_ptr_q];
      ifid_pc_d    = buf_pc_q[rd_ptr_q];
      ifid_pc4_d   = buf_pc_q[rd_ptr_q] + PC_INC;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_f_q       <= RESET_PC;
      pc_req_q     <= '0;
      buf_instr_q  <= '{default: '0};
      buf_pc_q     <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= PC_INC;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pc_req_q     <= pc_req_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign valid_d    = ifid_valid_q;
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign op_d       = ifid_instr_q[6:0];
  assign funct3_d   = ifid_instr_q[14:12];
  assign funct7_5_d = ifid_instr_q[30];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a RESET_PC=0 instance with a variable-latency memory and a RESET_PC=FFFF_FFFC instance.
module tb_if_fetch_stage;

`ifdef IF_FETCH_BYPASS_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 18);
  endfunction

  // Instance 1 signals
  logic        reset, imem_req_ready, imem_rsp_valid, redirect_valid, stall_d, flush_d;
  logic [31:0] imem_rsp_data, redirect_pc;
  logic        imem_req_valid, valid_d, funct7_5_d;
  logic [31:0] imem_req_addr, instr_d, pc_d, pc_plus4_d;
  logic [6:0]  op_d;
  logic [2:0]  funct3_d;
  int          lat;

  // Instance 2 signals
  logic        reset2, ready2, rsp_valid2, redirect2, stall2, flush2;
  logic [31:0] rsp_data2, redirect_pc2;
  logic        req_valid2, valid_d2, funct7_5_d2;
  logic [31:0] req_addr2, instr_d2, pc_d2, pc_plus4_d2;
  logic [6:0]  op_d2;
  logic [2:0]  funct3_d2;

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .flush_d(flush_d),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .op_d(op_d), .funct3_d(funct3_d), .funct7_5_d(funct7_5_d)
  );

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2),
    .imem_req_valid(req_valid2), .imem_req_ready(ready2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
    .stall_d(stall2), .flush_d(flush2),
    .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2),
    .op_d(op_d2), .funct3_d(funct3_d2), .funct7_5_d(funct7_5_d2)
  );

  // Memory for instance 1: response 'lat' cycles after acceptance.
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  always @(posedge clk) begin
    if (reset) begin
      m_pend <= 1'b0; m_cnt <= 0; m_addr <= '0;
      imem_rsp_valid <= 1'b0; imem_rsp_data <= '0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (m_pend) begin
        if (m_cnt <= 1) begin
          imem_rsp_valid <= 1'b1; imem_rsp_data <= mem_word(m_addr); m_pend <= 1'b0;
        end else m_cnt <= m_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        m_addr <= imem_req_addr;
        if (lat <= 1) begin
          imem_rsp_valid <= 1'b1; imem_rsp_data <= mem_word(imem_req_addr); m_pend <= 1'b0;
        end else begin
          m_pend <= 1'b1; m_cnt <= lat - 1;
        end
      end
    end
  end

  // Memory for instance 2: fixed 1-cycle latency.
  always @(posedge clk) begin
    if (reset2) begin
      rsp_valid2 <= 1'b0; rsp_data2 <= '0;
    end else begin
      rsp_valid2 <= req_valid2 && ready2;
      rsp_data2  <= mem_word(req_addr2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid_d: got %b expected 0", valid_d); end
    vectors++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr_d: got %h expected %h", instr_d, NOP); end
    vectors++; if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pc_d: got %h expected 0", pc_d); end
    vectors++; if (pc_plus4_d !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4_d: got %h expected 4", pc_plus4_d); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp;
    reset = 1'b0;
    tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr); end
    tick();
    repeat (EXTRA) tick();
    vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL first_latency_early: got valid_d=%b expected 0", valid_d); end
    tick();
    vectors++; if (valid_d !== 1'b1 || instr_d !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got valid=%b instr=%h expected 1/00500093", valid_d, instr_d); end
    vectors++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h4) begin errors++; $display("FAIL first_pc: got pc=%h pc4=%h expected 0/4", pc_d, pc_plus4_d); end
    vectors++; if (op_d !== 7'b0010011 || funct3_d !== 3'b000 || funct7_5_d !== 1'b0) begin errors++; $display("FAIL first_fields: got op=%b f3=%b f7_5=%b expected 0010011/000/0", op_d, funct3_d, funct7_5_d); end
    exp = 32'h4;
    for (int i = 0; i < 30 && exp != 32'h10; i++) begin
      tick();
      if (valid_d) begin
        vectors++; if (pc_d !== exp || instr_d !== mem_word(exp)) begin errors++; $display("FAIL stream_pc: got pc=%h instr=%h expected %h/%h", pc_d, instr_d, exp, mem_word(exp)); end
        exp = exp + 32'h4;
      end
    end
    vectors++; if (exp !== 32'h10) begin errors++; $display("FAIL stream_timeout: got next_pc=%h expected 00000010", exp); end
  endtask

  task automatic test_stall();
    logic [31:0] hpc, hinstr;
    for (int i = 0; i < 10 && !valid_d; i++) tick();
    hpc = pc_d; hinstr = instr_d;
    stall_d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (valid_d !== 1'b1 || pc_d !== hpc || instr_d !== hinstr) begin errors++; $display("FAIL stall_hold: got valid=%b pc=%h instr=%h expected 1/%h/%h", valid_d, pc_d, instr_d, hpc, hinstr); end
    end
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_fifo_full: got req_valid=%b expected 0", imem_req_valid); end
    stall_d = 1'b0;
    tick();
    vectors++; if (valid_d !== 1'b1 || pc_d !== hpc + 32'h4) begin errors++; $display("FAIL stall_release1: got valid=%b pc=%h expected 1/%h", valid_d, pc_d, hpc + 32'h4); end
    tick();
    vectors++; if (valid_d !== 1'b1 || pc_d !== hpc + 32'h8) begin errors++; $display("FAIL stall_release2: got valid=%b pc=%h expected 1/%h", valid_d, pc_d, hpc + 32'h8); end
`ifndef IF_FETCH_BYPASS_EN
    tick();
    vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL stall_depth: got valid=%b expected 0", valid_d); end
`endif
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        tick();
        if (valid_d) seen = 1'b1;
      end
      vectors++; if (!seen || pc_d !== hpc + 32'hC) begin errors++; $display("FAIL stall_resume: got seen=%b pc=%h expected 1/%h", seen, pc_d, hpc + 32'hC); end
    end
  endtask

  task automatic test_redirect_wait();
    bit seen = 1'b0;
    lat = 3;
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL redir_kill: got valid_d=%b expected 0", valid_d); end
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_drop1: got req_valid=%b expected 0", imem_req_valid); end
    tick();
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_drop2: got req_valid=%b expected 0", imem_req_valid); end
    tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_req: got valid=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr); end
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (valid_d) seen = 1'b1;
    end
    vectors++; if (!seen || pc_d !== 32'h100 || instr_d !== mem_word(32'h100)) begin errors++; $display("FAIL redir_first: got seen=%b pc=%h instr=%h expected 1/00000100/%h", seen, pc_d, instr_d, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_rsp_flush();
    logic [31:0] hpc;
    bit got = 1'b0, seen = 1'b0;
    lat = 2;
    for (int i = 0; i < 20 && !valid_d; i++) tick();
    hpc = pc_d;
    stall_d = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (imem_rsp_valid) got = 1'b1;
    end
    vectors++; if (!got) begin errors++; $display("FAIL rsp_wait_timeout: got no response expected one"); end
    redirect_valid = 1'b1; redirect_pc = 32'h200; flush_d = 1'b1;
    tick();
    redirect_valid = 1'b0; flush_d = 1'b0; stall_d = 1'b0;
    #1;
    vectors++; if (valid_d !== 1'b0 || instr_d !== NOP || op_d !== 7'b0010011 || funct3_d !== 3'b000) begin errors++; $display("FAIL flush_wins: got valid=%b instr=%h op=%b f3=%b expected 0/00000013/0010011/000", valid_d, instr_d, op_d, funct3_d); end
    vectors++; if (pc_d !== hpc) begin errors++; $display("FAIL flush_pc_hold: got %h expected %h", pc_d, hpc); end
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rsp_redir_req: got valid=%b addr=%h expected 1/00000200", imem_req_valid, imem_req_addr); end
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (valid_d) seen = 1'b1;
    end
    vectors++; if (!seen || pc_d !== 32'h200 || instr_d !== mem_word(32'h200)) begin errors++; $display("FAIL rsp_redir_first: got seen=%b pc=%h instr=%h expected 1/00000200/%h", seen, pc_d, instr_d, mem_word(32'h200)); end
  endtask

  task automatic test_ready_low();
    logic [31:0] cap;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    cap = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== cap) begin errors++; $display("FAIL ready_low_hold: got valid=%b addr=%h expected 1/%h", imem_req_valid, imem_req_addr, cap); end
    end
    imem_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== cap + 32'h4) begin errors++; $display("FAIL ready_advance: got valid=%b addr=%h expected 1/%h", imem_req_valid, imem_req_addr, cap + 32'h4); end
  endtask

  task automatic test_wrap();
    logic [31:0] a0 = '1, a1 = '1;
    int n = 0;
    bit seen = 1'b0;
    reset2 = 1'b0;
    for (int i = 0; i < 20 && !(n == 2 && seen); i++) begin
      tick();
      if (req_valid2 && n == 0) begin a0 = req_addr2; n = 1; end
      else if (req_valid2 && n == 1) begin a1 = req_addr2; n = 2; end
      if (valid_d2 && !seen) begin
        seen = 1'b1;
        vectors++; if (pc_d2 !== 32'hFFFF_FFFC || pc_plus4_d2 !== 32'h0) begin errors++; $display("FAIL wrap_pc_d: got pc=%h pc4=%h expected fffffffc/00000000", pc_d2, pc_plus4_d2); end
      end
    end
    vectors++; if (a0 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got %h expected fffffffc", a0); end
    vectors++; if (a1 !== 32'h0) begin errors++; $display("FAIL wrap_req1: got %h expected 00000000", a1); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !req_valid2; i++) tick();
    tick();
    reset2 = 1'b1;
    tick();
    vectors++; if (valid_d2 !== 1'b0 || instr_d2 !== NOP || pc_d2 !== 32'h0 || pc_plus4_d2 !== 32'h4) begin errors++; $display("FAIL midreset_ifid: got valid=%b instr=%h pc=%h pc4=%h expected 0/00000013/0/4", valid_d2, instr_d2, pc_d2, pc_plus4_d2); end
    vectors++; if (req_valid2 !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b expected 0", req_valid2); end
    reset2 = 1'b0;
    tick();
    vectors++; if (req_valid2 !== 1'b1 || req_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL midreset_restart: got valid=%b addr=%h expected 1/fffffffc", req_valid2, req_addr2); end
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (valid_d2) seen = 1'b1;
    end
    vectors++; if (!seen || pc_d2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL midreset_first: got seen=%b pc=%h expected 1/fffffffc", seen, pc_d2); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    stall_d = 1'b0; flush_d = 1'b0; lat = 1;
    reset2 = 1'b1; ready2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = '0; stall2 = 1'b0; flush2 = 1'b0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp_flush();
    test_ready_low();
    test_wrap();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
